kernel_scan_controller: RTL and testbench

KERNEL_SCAN_CONTROLLER -- requirements
Module: kernel_scan_controller

---
 rtl/kernel_scan_controller.sv | 154 +++++++++++++++
 tb/tb_kernel_scan_controller.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/kernel_scan_controller.sv
// rtl/kernel_scan_controller.sv - 3x3 kernel scan over an 8x8 frame, one tap per cycle
// Issues zero-padded neighbour reads in raster order and re-times each tap onto the read-data cycle.
module kernel_scan_controller #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic              mem_rd_en,
  output logic [2:0]        mem_addr_width,
  output logic [2:0]        mem_addr_depth,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              tap_valid,
  output logic [DATA_W-1:0] tap_data,
  output logic [3:0]        tap_idx,
  output logic              tap_pad,
  output logic [2:0]        center_width,
  output logic [2:0]        center_depth,
  output logic              win_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_e;

  state_e      state_q, state_d;
  logic [2:0]  cw_q, cw_d, cd_q, cd_d;
  logic [3:0]  tap_q, tap_d;
  logic [2:0]  aw_q, aw_d, ad_q, ad_d;
  logic        tv_q, tv_d, tpad_q, tpad_d, tlast_q, tlast_d;
  logic [3:0]  tidx_q, tidx_d;
  logic [2:0]  tcw_q, tcw_d, tcd_q, tcd_d;

  logic signed [3:0] off_w, off_d, nb_w, nb_d;
  logic              inb;
  logic              issue;

  always_comb begin
    off_w = 4'sd1;
    off_d = 4'sd1;
    case (tap_q)
      4'd0, 4'd3, 4'd6: off_w = -4'sd1;
      4'd1, 4'd4, 4'd7: off_w = 4'sd0;
      default:          off_w = 4'sd1;
    endcase
    case (tap_q)
      4'd0, 4'd1, 4'd2: off_d = -4'sd1;
      4'd3, 4'd4, 4'd5: off_d = 4'sd0;
      default:          off_d = 4'sd1;
    endcase
  end

  // 4-bit signed sum: -1 and 8 both land with bit 3 set, so one bit flags out-of-frame.
  assign nb_w  = $signed({1'b0, cw_q}) + off_w;
  assign nb_d  = $signed({1'b0, cd_q}) + off_d;
  assign inb   = ~nb_w[3] & ~nb_d[3];
  assign issue = (state_q == ISSUE) & ~abort;

  assign mem_rd_en      = issue & inb;
  assign mem_addr_width = mem_rd_en ? nb_w[2:0] : aw_q;
  assign mem_addr_depth = mem_rd_en ? nb_d[2:0] : ad_q;
  assign aw_d           = mem_addr_width;
  assign ad_d           = mem_addr_depth;

  always_comb begin
    state_d = state_q;
    cw_d    = cw_q;
    cd_d    = cd_q;
    tap_d   = tap_q;
    tv_d    = 1'b0;
    tidx_d  = tidx_q;
    tpad_d  = tpad_q;
    tcw_d   = tcw_q;
    tcd_d   = tcd_q;
    tlast_d = tlast_q;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d = ISSUE;
          cw_d    = 3'd0;
          cd_d    = 3'd0;
          tap_d   = 4'd0;
        end
      end
      ISSUE: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          tv_d    = 1'b1;
          tidx_d  = tap_q;
          tpad_d  = ~inb;
          tcw_d   = cw_q;
          tcd_d   = cd_q;
          tlast_d = (tap_q == 4'd8);
          if (tap_q == 4'd8) begin
            tap_d = 4'd0;
            if (cw_q == 3'd7 && cd_q == 3'd7) begin
              state_d = DRAIN;
            end else begin
              cw_d = cw_q + 3'd1;
              if (cw_q == 3'd7) cd_d = cd_q + 3'd1;
            end
          end else begin
            tap_d = tap_q + 4'd1;
          end
        end
      end
      DRAIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cw_q    <= 3'd0;
      cd_q    <= 3'd0;
      tap_q   <= 4'd0;
      aw_q    <= 3'd0;
      ad_q    <= 3'd0;
      tv_q    <= 1'b0;
      tidx_q  <= 4'd0;
      tpad_q  <= 1'b0;
      tcw_q   <= 3'd0;
      tcd_q   <= 3'd0;
      tlast_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cw_q    <= cw_d;
      cd_q    <= cd_d;
      tap_q   <= tap_d;
      aw_q    <= aw_d;
      ad_q    <= ad_d;
      tv_q    <= tv_d;
      tidx_q  <= tidx_d;
      tpad_q  <= tpad_d;
      tcw_q   <= tcw_d;
      tcd_q   <= tcd_d;
      tlast_q <= tlast_d;
    end
  end

  assign tap_valid    = tv_q;
  assign tap_data     = (tv_q && !tpad_q) ? mem_rd_data : '0;
  assign tap_pad      = tv_q & tpad_q;
  assign win_last     = tv_q & tlast_q;
  assign tap_idx      = tidx_q;
  assign center_width = tcw_q;
  assign center_depth = tcd_q;
  assign busy         = (state_q != IDLE);
  assign done         = (state_q == DRAIN) & ~abort;

endmodule

// File: tb/tb_kernel_scan_controller.sv
// tb/tb_kernel_scan_controller.sv - self-checking bench for kernel_scan_controller
// Vector table for the first window plus model-checked full, aborted, held-start and reset scans.
module tb_kernel_scan_controller;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst, start, abort;
  logic          mem_rd_en;
  logic [2:0]    mem_addr_width, mem_addr_depth;
  logic [DW-1:0] mem_rd_data;
  logic          tap_valid;
  logic [DW-1:0] tap_data;
  logic [3:0]    tap_idx;
  logic          tap_pad;
  logic [2:0]    center_width, center_depth;
  logic          win_last, busy, done;

  kernel_scan_controller #(.DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .mem_rd_en(mem_rd_en), .mem_addr_width(mem_addr_width), .mem_addr_depth(mem_addr_depth),
    .mem_rd_data(mem_rd_data), .tap_valid(tap_valid), .tap_data(tap_data), .tap_idx(tap_idx),
    .tap_pad(tap_pad), .center_width(center_width), .center_depth(center_depth),
    .win_last(win_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [64];

  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= mem[{mem_addr_depth, mem_addr_width}];
    else           mem_rd_data <= DW'($urandom);
  end

  typedef struct {
    logic s, a, busy, rd, tv;
    int   idx;
    logic pad;
    int   data;
    logic last;
  } vec_t;
  vec_t tbl [13];

  int tests = 0;
  int fails = 0;
  int m_inb [576];
  int m_w [576];
  int m_d [576];
  int m_data [576];
  int last_w, last_d;
  bit known;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Expected issue order and tap results derived straight from the kernel geometry.
  task automatic build_model();
    for (int c = 0; c < 64; c++) begin
      for (int t = 0; t < 9; t++) begin
        int k, nw, nd;
        k  = c * 9 + t;
        nw = c % 8 + t % 3 - 1;
        nd = c / 8 + t / 3 - 1;
        m_inb[k] = (nw >= 0 && nw < 8 && nd >= 0 && nd < 8) ? 1 : 0;
        m_w[k] = nw;
        m_d[k] = nd;
        if (m_inb[k] != 0) m_data[k] = int'(mem[nd * 8 + nw]);
        else               m_data[k] = 0;
      end
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < 64; i++) mem[i] = DW'($urandom);
  endtask

  task automatic scan(input int abort_at, input bit hold);
    int n, reads, pads;
    n = 0; reads = 0; pads = 0;
    build_model();
    start = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    for (int k = 0; k <= 577; k++) begin
      chk($sformatf("busy k=%0d", k), busy, (k <= 576));
      chk($sformatf("done k=%0d", k), done, (k == 576));
      chk($sformatf("tap_valid k=%0d", k), tap_valid, (k >= 1 && k <= 576));
      if (k < 576) begin
        chk($sformatf("rd_en k=%0d", k), mem_rd_en, m_inb[k]);
        reads += int'(mem_rd_en);
        if (m_inb[k] != 0) begin
          chk($sformatf("addr_w k=%0d", k), mem_addr_width, m_w[k]);
          chk($sformatf("addr_d k=%0d", k), mem_addr_depth, m_d[k]);
          last_w = m_w[k]; last_d = m_d[k]; known = 1'b1;
        end else if (known) begin
          chk($sformatf("hold_w k=%0d", k), mem_addr_width, last_w);
          chk($sformatf("hold_d k=%0d", k), mem_addr_depth, last_d);
        end
      end
      if (tap_valid && n < 576) begin
        chk($sformatf("tap_idx n=%0d", n), tap_idx, n % 9);
        chk($sformatf("tap_pad n=%0d", n), tap_pad, (m_inb[n] == 0));
        chk($sformatf("tap_data n=%0d", n), tap_data, m_data[n]);
        chk($sformatf("center_w n=%0d", n), center_width, (n / 9) % 8);
        chk($sformatf("center_d n=%0d", n), center_depth, n / 72);
        chk($sformatf("win_last n=%0d", n), win_last, (n % 9 == 8));
        pads += int'(tap_pad);
        n++;
      end
      if (k == abort_at) begin
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort busy", busy, 0);
        chk("abort tap_valid", tap_valid, 0);
        chk("abort done", done, 0);
        @(posedge clk); #1;
        chk("abort tap_valid+1", tap_valid, 0);
        chk("abort busy+1", busy, 0);
        known = 1'b0;
        return;
      end
      if (k < 577) begin
        @(posedge clk); #1;
      end
    end
    chk("scan tap count", n, 576);
    chk("scan reads", reads, 484);
    chk("scan pads", pads, 92);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int rd_cnt;
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 0, 1'b1, 0, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1, 1'b1, 0, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2, 1'b1, 0, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 3, 1'b1, 0, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4, 1'b0, 0, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5, 1'b0, 1, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 6, 1'b1, 0, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 7, 1'b0, 8, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8, 1'b0, 9, 1'b1};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0};

    rst = 1'b1; start = 1'b0; abort = 1'b0;
    #7;
    chk("reset busy", busy, 0);
    chk("reset tap_valid", tap_valid, 0);
    chk("reset rd_en", mem_rd_en, 0);
    chk("reset addr_w", mem_addr_width, 0);
    chk("reset addr_d", mem_addr_depth, 0);
    chk("reset center_w", center_width, 0);
    chk("reset center_d", center_depth, 0);
    chk("reset done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    known = 1'b1; last_w = 0; last_d = 0;

    for (int i = 0; i < 64; i++) mem[i] = DW'(i);
    rd_cnt = 0;
    for (int i = 0; i < 13; i++) begin
      start = tbl[i].s; abort = tbl[i].a;
      @(posedge clk); #1;
      rd_cnt += int'(mem_rd_en);
      chk($sformatf("vec%0d busy", i), busy, tbl[i].busy);
      chk($sformatf("vec%0d rd_en", i), mem_rd_en, tbl[i].rd);
      chk($sformatf("vec%0d tap_valid", i), tap_valid, tbl[i].tv);
      chk($sformatf("vec%0d tap_pad", i), tap_pad, tbl[i].pad);
      chk($sformatf("vec%0d tap_data", i), tap_data, tbl[i].data);
      chk($sformatf("vec%0d win_last", i), win_last, tbl[i].last);
      if (tbl[i].tv) begin
        chk($sformatf("vec%0d tap_idx", i), tap_idx, tbl[i].idx);
        chk($sformatf("vec%0d center_w", i), center_width, 0);
        chk($sformatf("vec%0d center_d", i), center_depth, 0);
      end
    end
    start = 1'b0; abort = 1'b0;
    chk("first window reads", rd_cnt, 4);
    known = 1'b0;

    scan(175, 1'b0);
    scan(-1, 1'b0);

    fill_random();
    scan(-1, 1'b1);
    @(posedge clk); #1;
    chk("held start rescan busy", busy, 1);
    chk("held start rescan rd_en", mem_rd_en, 0);
    start = 1'b0; abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("held start abort busy", busy, 0);
    known = 1'b0;

    for (int r = 0; r < 3; r++) begin
      fill_random();
      repeat ($urandom_range(0, 4)) @(posedge clk);
      #1;
      scan(int'($urandom_range(0, 575)), 1'b0);
      fill_random();
      scan(-1, 1'b0);
    end

    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (50) @(posedge clk);
    #4;
    rst = 1'b1;
    #1;
    chk("async rst busy", busy, 0);
    chk("async rst tap_valid", tap_valid, 0);
    chk("async rst rd_en", mem_rd_en, 0);
    chk("async rst addr_w", mem_addr_width, 0);
    chk("async rst addr_d", mem_addr_depth, 0);
    chk("async rst tap_idx", tap_idx, 0);
    chk("async rst tap_data", tap_data, 0);
    chk("async rst center_w", center_width, 0);
    chk("async rst center_d", center_depth, 0);
    chk("async rst win_last", win_last, 0);
    chk("async rst done", done, 0);
    @(posedge clk); #3;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk($sformatf("post rst tap_valid %0d", i), tap_valid, 0);
      chk($sformatf("post rst busy %0d", i), busy, 0);
    end
    known = 1'b1; last_w = 0; last_d = 0;
    fill_random();
    scan(-1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
